// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requester and the bit-serial add/subtract controller.
// The requester drives the operands and the start strobe; the controller drives status and results.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             overflow;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, c_out, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, c_out, overflow
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared full adder processes the operands LSB
// first, one bit per clock. Subtraction is a + ~b + 1, with the +1 preset into the carry flop.
module full_adder (
   output logic sum,
   output logic c_out,
   input  logic a,
   input  logic b,
   input  logic c_in
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   serial_add_ctrl_if.slave bus
);
   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] MSB_CNT  = CNT_W'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] sh_a_r;
   logic [WIDTH-1:0] sh_b_r;
   logic [WIDTH-1:0] sh_s_r;
   logic [WIDTH-1:0] result_r;
   logic             carry_r;
   logic             cin_msb_r;
   logic             c_out_r;
   logic             overflow_r;
   logic             busy_s;
   logic             done_s;
   logic             last_bit_s;
   logic             fa_sum_s;
   logic             fa_c_out_s;

   full_adder u_fa (
      .sum   (fa_sum_s),
      .c_out (fa_c_out_s),
      .a     (sh_a_r[0]),
      .b     (sh_b_r[0]),
      .c_in  (carry_r)
   );

   assign last_bit_s = (cnt_r == LAST_CNT);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; DONE always falls back to IDLE so start cannot queue
   always_comb begin
      state_next_s = IDLE;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_bit_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Status decode from the registered state only
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_r)
         IDLE: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
         RUN: begin
            busy_s = 1'b1;
            done_s = 1'b0;
         end
         DONE: begin
            busy_s = 1'b0;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

   // Operand shifters, carry feedback, bit counter and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r      <= '0;
         sh_a_r     <= '0;
         sh_b_r     <= '0;
         sh_s_r     <= '0;
         carry_r    <= 1'b0;
         cin_msb_r  <= 1'b0;
         result_r   <= '0;
         c_out_r    <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  sh_a_r  <= bus.a;
                  sh_b_r  <= bus.sub ? ~bus.b : bus.b;
                  carry_r <= bus.sub;
                  cnt_r   <= '0;
               end
            end
            RUN: begin
               sh_a_r  <= {1'b0, sh_a_r[WIDTH-1:1]};
               sh_b_r  <= {1'b0, sh_b_r[WIDTH-1:1]};
               sh_s_r  <= {fa_sum_s, sh_s_r[WIDTH-1:1]};
               carry_r <= fa_c_out_s;
               cnt_r   <= cnt_r + CNT_W'(1);
               // Carry out of bit WIDTH-2 is the carry into the sign bit
               if (cnt_r == MSB_CNT) begin
                  cin_msb_r <= fa_c_out_s;
               end
               if (last_bit_s) begin
                  result_r   <= {fa_sum_s, sh_s_r[WIDTH-1:1]};
                  c_out_r    <= fa_c_out_s;
                  overflow_r <= cin_msb_r ^ fa_c_out_s;
               end
            end
            DONE: begin
               cnt_r <= '0;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_s;
   assign bus.done     = done_s;
   assign bus.result   = result_r;
   assign bus.c_out    = c_out_r;
   assign bus.overflow = overflow_r;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller. It time-shares a single instance of the team's full_adder (ports sum, c_out, a, b, c_in) across all bit positions of a WIDTH-bit operation, one bit per clock, LSB first.
- It sequences operand shifting, carry feedback, the bit counter and the start/busy/done handshake.
- It sits between a simple requester (lab top / testbench) and the 1-bit adder datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while operation in progress (RUN).
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  sum/difference, registered.
- c_out  output  1  final carry out (for sub: 1 = no borrow, i.e. a ≥ b unsigned).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (synchronous, at any time including mid-RUN):
  - state ← IDLE; busy, done, c_out, overflow ← 0; result ← 0.
  - Internal shift registers, carry flop and counter ← 0.
  - The in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - Load shA ← a, shB ← (sub ? ~b : b), carry ← sub, cnt ← 0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - The full_adder inputs are shA[0], shB[0], carry.
  - shA, shB shift right by 1. The sum bit shifts into the MSB of internal shS (right shift). carry ← fa c_out.
  - On cnt = WIDTH-2, latch cinMSB ← carry (the carry into the MSB bit). cnt increments.
  - On cnt = WIDTH-1: result ← final shS including this bit; c_out ← fa c_out; overflow ← cinMSB XOR fa c_out. Go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally IDLE.
- Timing (start high in cycle 0):
  - busy=1 in cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1 with result/c_out/overflow valid.
  - Earliest next start is cycle WIDTH+2 (IDLE).
- busy = (state==RUN); done = (state==DONE); both are decoded from registered state, so there is no combinational path from inputs.
- result, c_out and overflow change only on the RUN→DONE edge or on reset. They hold their last values through IDLE until the next completion; intermediate partial sums are never visible.
- start asserted in RUN or DONE is ignored and does not queue. a/b/sub changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. Subtraction is implemented as a + ~b + 1 via the carry preset.

Test Plan:
- WIDTH=8, start, a=0x3C, b=0x05, sub=0 → busy cycles 1..8, done in cycle 9, result=0x41, c_out=0, overflow=0.
- a=0xFF, b=0x01, sub=0 → result=0x00, c_out=1, overflow=0; a=0x7F, b=0x01, sub=0 → result=0x80, c_out=0, overflow=1.
- a=0x05, b=0x07, sub=1 → result=0xFE, c_out=0 (borrow), overflow=0; a=0x80, b=0x01, sub=1 → result=0x7F, c_out=1, overflow=1.
- Start 0x10+0x20, then hold start=1 with new operands a=0xAA, b=0x11 during busy → exactly one done pulse, result=0x30; start reissued in IDLE → 0xBB.
- Start 0x3C+0x05, assert reset in cycle 4 → next cycle busy=0, done=0, result=0x00; no done pulse follows; a fresh start → 0x41 after 9 cycles.
- Back-to-back: start in cycle 0 and in cycle 10 (first IDLE) → two done pulses at cycles 9 and 19, result held between them.
